spell_mem_banked: RTL and testbench

- Parametrised on-chip code/data memory for the SPELL core, replacing the fixed 32-byte code / 8-byte data store.
- Sizes, address width and access latency are parameters. Each request runs exactly once through an explicit request FSM.
- Adds out-of-range and write-protect error reporting and a code-region lock.
- Sits between the SPELL execution unit and its memory select/ready handshake.

---
 rtl/spell_mem_pkg.sv | 9 +
 rtl/spell_mem_bank.sv | 23 ++
 rtl/spell_mem_banked.sv | 106 ++++++++++
 tb/tb_spell_mem_banked.sv | 139 +++++++++++++
 4 files changed

// File: rtl/spell_mem_pkg.sv
// spell_mem_pkg: shared FSM states, fill constants and counter sizing for the SPELL memory
package spell_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam logic [7:0] CODE_FILL = 8'hFF;
  localparam logic [7:0] DATA_FILL = 8'h00;
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction
endpackage

// File: rtl/spell_mem_bank.sv
// spell_mem_bank: byte array cleared on reset, one synchronous write port, combinational read
// ports: clk, rst_n (sync, active-low), we_i/addr_i/wdata_i write, rdata_o = mem[addr_i]
module spell_mem_bank #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/spell_mem_banked.sv
// spell_mem_banked: parametrised SPELL code/data memory with request FSM, range and lock errors
// ports: clk, rst_n (sync, active-low); request select/addr/data_in/memory_type_data/write,
//        code_lock; response data_out/data_ready/err
module spell_mem_banked
  import spell_mem_pkg::*;
#(
  parameter int CODE_SIZE = 32,
  parameter int DATA_SIZE = 8,
  parameter int ADDR_W    = 8,
  parameter int LATENCY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              select,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  input  logic              memory_type_data,
  input  logic              write,
  input  logic              code_lock,
  output logic [7:0]        data_out,
  output logic              data_ready,
  output logic              err
);
  localparam int CAW = $clog2(CODE_SIZE);
  localparam int DAW = $clog2(DATA_SIZE);
  localparam int CW  = cnt_width(LATENCY);
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, e_addr;
  logic [7:0]        wdata_q, wdata_d, e_wdata;
  logic              type_q, type_d, e_type;
  logic              wr_q, wr_d, e_wr;
  logic [7:0]        dout_q, dout_d, rd_val, code_rdata, data_rdata;
  logic              rdy_q, rdy_d, err_q, err_d;
  logic              idle, exec, in_range, code_we, data_we;
  // With zero latency the access executes on the capture edge, so it must use the live inputs.
  assign idle     = state_q == IDLE;
  assign e_addr   = idle ? addr : addr_q;
  assign e_wdata  = idle ? data_in : wdata_q;
  assign e_type   = idle ? memory_type_data : type_q;
  assign e_wr     = idle ? write : wr_q;
  assign exec     = select && ((idle && LATENCY == 0) || (state_q == WAIT && cnt_q == '0));
  assign in_range = e_type ? (32'(e_addr) < 32'(DATA_SIZE)) : (32'(e_addr) < 32'(CODE_SIZE));
  assign code_we  = exec && e_wr && in_range && !e_type && !code_lock;
  assign data_we  = exec && e_wr && in_range && e_type;
  assign rd_val   = !in_range ? (e_type ? DATA_FILL : CODE_FILL) : (e_type ? data_rdata : code_rdata);
  spell_mem_bank #(.DEPTH(CODE_SIZE)) u_code (
    .clk(clk), .rst_n(rst_n), .we_i(code_we), .addr_i(e_addr[CAW-1:0]),
    .wdata_i(e_wdata), .rdata_o(code_rdata)
  );
  spell_mem_bank #(.DEPTH(DATA_SIZE)) u_data (
    .clk(clk), .rst_n(rst_n), .we_i(data_we), .addr_i(e_addr[DAW-1:0]),
    .wdata_i(e_wdata), .rdata_o(data_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    wr_d    = wr_q;
    if (idle && select) begin
      addr_d  = addr;
      wdata_d = data_in;
      type_d  = memory_type_data;
      wr_d    = write;
      cnt_d   = CW'(LATENCY - 1);
      state_d = (LATENCY == 0) ? DONE : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = !select ? IDLE : (cnt_q == '0 ? DONE : WAIT);
    end else if (state_q == DONE && !select) begin
      state_d = IDLE;
    end
    rdy_d  = exec ? 1'b1 : (state_q == DONE && !select) ? 1'b0 : rdy_q;
    err_d  = exec ? (!in_range || (e_wr && !e_type && code_lock)) :
             (state_q == DONE && !select) ? 1'b0 : err_q;
    dout_d = (exec && !e_wr) ? rd_val : dout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      type_q  <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= 8'h00;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end
  assign data_out   = dout_q;
  assign data_ready = rdy_q;
  assign err        = err_q;
endmodule

// File: tb/tb_spell_mem_banked.sv
// tb_spell_mem_banked: directed checks of zero- and three-cycle-latency instances
module tb_spell_mem_banked;
  logic clk = 1'b0;
  logic rst0_n = 1'b0, rst3_n = 1'b0, sel0 = 1'b0, sel3 = 1'b0;
  logic [7:0] addr = 8'h00, din = 8'h00;
  logic mtd = 1'b0, wr = 1'b0, lock = 1'b0;
  logic [7:0] dout0, dout3;
  logic rdy0, rdy3, err0, err3;
  int n_chk = 0, n_fail = 0;
  int dw0 = 0, cw3 = 0;
  logic [7:0] o;
  logic e;
  int n;
  always #5 clk = ~clk;
  spell_mem_banked #(.CODE_SIZE(32), .DATA_SIZE(8), .ADDR_W(8), .LATENCY(0)) d0 (
    .clk(clk), .rst_n(rst0_n), .select(sel0), .addr(addr), .data_in(din),
    .memory_type_data(mtd), .write(wr), .code_lock(lock),
    .data_out(dout0), .data_ready(rdy0), .err(err0)
  );
  spell_mem_banked #(.CODE_SIZE(32), .DATA_SIZE(8), .ADDR_W(8), .LATENCY(3)) d3 (
    .clk(clk), .rst_n(rst3_n), .select(sel3), .addr(addr), .data_in(din),
    .memory_type_data(mtd), .write(wr), .code_lock(lock),
    .data_out(dout3), .data_ready(rdy3), .err(err3)
  );
  always @(posedge clk) begin
    if (d0.u_data.we_i) dw0++;
    if (d3.u_code.we_i) cw3++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One full handshake; a_alt replaces addr after the capture edge. n = edges until data_ready.
  task automatic access(input bit w3, input bit dt, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] a_alt,
                        output logic [7:0] ov, output logic ev, output int nv);
    @(negedge clk);
    addr = a; din = d; mtd = dt; wr = w;
    if (w3) sel3 = 1'b1; else sel0 = 1'b1;
    nv = 0;
    do begin
      @(posedge clk); #1;
      nv++;
      if (nv == 1) addr = a_alt;
    end while (!(w3 ? rdy3 : rdy0) && nv < 20);
    check("ready_seen", w3 ? rdy3 : rdy0, 1);
    ov = w3 ? dout3 : dout0;
    ev = w3 ? err3 : err0;
    @(negedge clk);
    sel0 = 1'b0; sel3 = 1'b0;
    @(posedge clk); #1;
    check("drop_rdy", w3 ? rdy3 : rdy0, 0);
    check("drop_err", w3 ? err3 : err0, 0);
  endtask
  initial begin
    int base;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", rdy0, 0); check("rst_err", err0, 0); check("rst_dout", dout0, 8'h00);
    @(negedge clk); rst0_n = 1'b1; rst3_n = 1'b1;
    access(0, 0, 0, 8'd0, 8'h00, 8'd0, o, e, n);
    check("rd_code0", o, 8'h00); check("rd_code0_err", e, 0); check("lat0", n, 1);
    access(0, 1, 0, 8'd0, 8'h00, 8'd0, o, e, n);
    check("rd_data0", o, 8'h00); check("rd_data0_err", e, 0);
    access(0, 0, 1, 8'd5, 8'hA5, 8'd5, o, e, n);
    check("wr_code5_err", e, 0); check("wr_dout_kept", o, 8'h00);
    access(0, 1, 1, 8'd3, 8'h3C, 8'd3, o, e, n);
    check("wr_data3_err", e, 0);
    access(0, 0, 0, 8'd5, 8'h00, 8'd5, o, e, n);
    check("rd_code5", o, 8'hA5); check("rd_code5_err", e, 0);
    access(0, 1, 0, 8'd3, 8'h00, 8'd3, o, e, n);
    check("rd_data3", o, 8'h3C);
    access(0, 0, 0, 8'd32, 8'h00, 8'd32, o, e, n);
    check("oor_code", o, 8'hFF); check("oor_code_err", e, 1);
    access(0, 1, 0, 8'd8, 8'h00, 8'd8, o, e, n);
    check("oor_data", o, 8'h00); check("oor_data_err", e, 1);
    access(0, 1, 1, 8'd9, 8'hEE, 8'd9, o, e, n);
    check("oor_wr_err", e, 1);
    access(0, 1, 0, 8'd1, 8'h00, 8'd1, o, e, n);
    check("oor_wr_nowrap", o, 8'h00);
    lock = 1'b1;
    access(0, 0, 1, 8'd5, 8'h11, 8'd5, o, e, n);
    check("lock_wr_err", e, 1);
    access(0, 0, 0, 8'd5, 8'h00, 8'd5, o, e, n);
    check("lock_rd_code5", o, 8'hA5); check("lock_rd_err", e, 0);
    access(0, 1, 1, 8'd2, 8'h5A, 8'd2, o, e, n);
    check("lock_data_wr_err", e, 0);
    access(0, 1, 0, 8'd2, 8'h00, 8'd2, o, e, n);
    check("lock_data_rd", o, 8'h5A);
    lock = 1'b0;
    @(negedge clk);
    addr = 8'd4; din = 8'h99; mtd = 1'b1; wr = 1'b1; sel0 = 1'b1;
    base = dw0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rdy0 && n < 20);
    repeat (5) @(posedge clk);
    #1;
    check("hold_rdy", rdy0, 1);
    @(negedge clk); sel0 = 1'b0;
    @(posedge clk); #1;
    check("hold_write_count", dw0 - base, 1);
    access(0, 1, 0, 8'd4, 8'h00, 8'd4, o, e, n);
    check("hold_rd_data4", o, 8'h99);
    access(1, 1, 1, 8'd1, 8'h22, 8'd1, o, e, n);
    check("lat3_wr_err", e, 0); check("lat3_wr_lat", n - 1, 3);
    access(1, 1, 0, 8'd1, 8'h00, 8'd3, o, e, n);
    check("lat3_captured_addr", o, 8'h22); check("lat3_rd_lat", n - 1, 3);
    @(negedge clk);
    addr = 8'd1; din = 8'h77; mtd = 1'b1; wr = 1'b1; sel3 = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); sel3 = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen |= rdy3; end
    check("abort_no_rdy", seen, 0);
    access(1, 1, 0, 8'd1, 8'h00, 8'd1, o, e, n);
    check("abort_old_val", o, 8'h22);
    @(negedge clk);
    addr = 8'd2; din = 8'h44; mtd = 1'b0; wr = 1'b1; sel3 = 1'b1;
    base = cw3;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst3_n = 1'b0; sel3 = 1'b0;
    @(posedge clk); #1;
    check("rstw_rdy", rdy3, 0); check("rstw_err", err3, 0); check("rstw_dout", dout3, 8'h00);
    @(negedge clk); rst3_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstw_no_write", cw3 - base, 0);
    access(1, 0, 0, 8'd2, 8'h00, 8'd2, o, e, n);
    check("rstw_code2", o, 8'h00);
    access(1, 1, 0, 8'd1, 8'h00, 8'd1, o, e, n);
    check("rst_cleared_data1", o, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
